// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the fetch PC, reads the ROM and buffers
// {pc, inst, fault} entries in a small FIFO for decode.
module ifu_fetch #(
    parameter logic [63:0] RST_PC = 64'h8000_0000,
    parameter int          DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] rom_pc,
    input  logic [31:0] rom_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_fault,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [31:0] fetch_cnt
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   FULL    = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        fault;
    } entry_t;

    entry_t        buffer [DEPTH];
    entry_t        newEntry;
    entry_t        head;
    logic [AW-1:0] rdPtr;
    logic [AW-1:0] wrPtr;
    logic [AW:0]   count;
    logic [63:0]   pc;
    logic          halted;
    logic [31:0]   fetchCnt;
    logic          push;
    logic          pop;
    logic          misaligned;

    assign misaligned = pc[1:0] != 2'b00;
    assign out_valid  = count != '0;
    assign pop        = out_valid && out_ready;
    // A full buffer may still push when the head leaves in the same cycle.
    assign push       = !redirect_valid && !halted && ((count < FULL) || pop);

    always_comb begin
        newEntry.pc    = pc;
        newEntry.inst  = misaligned ? NOP : rom_inst;
        newEntry.fault = misaligned;
    end

    // Outputs come only from stored state; zeros when empty.
    assign head      = out_valid ? buffer[rdPtr] : '0;
    assign out_pc    = head.pc;
    assign out_inst  = head.inst;
    assign out_fault = head.fault;
    assign rom_pc    = pc;
    assign fetch_cnt = fetchCnt;

    always_ff @(posedge clk) begin
        if (push)
            buffer[wrPtr] <= newEntry;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RST_PC;
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            halted   <= 1'b0;
            fetchCnt <= '0;
        end else begin
            if (pop)
                fetchCnt <= fetchCnt + 32'd1;
            if (redirect_valid) begin
                // Head handshake above still counts; everything else is dropped.
                pc     <= redirect_pc;
                halted <= 1'b0;
                rdPtr  <= '0;
                wrPtr  <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wrPtr <= wrPtr + PTR_ONE;
                    if (misaligned)
                        halted <= 1'b1;
                    else
                        pc <= pc + 64'd4;
                end
                if (pop)
                    rdPtr <= rdPtr + PTR_ONE;
                case ({push, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end
endmodule
